// File: rtl/serial_subtractor_8_if.sv
// rtl/serial_subtractor_8_if.sv - operand/result bus for the bit-serial subtractor
interface serial_subtractor_8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             bOut;
  logic             V;

  modport master (
    output start, x, y, b0,
    input  busy, done, D, bOut, V
  );

  modport slave (
    input  start, x, y, b0,
    output busy, done, D, bOut, V
  );
endinterface

// File: rtl/serial_subtractor_8.sv
// rtl/serial_subtractor_8.sv - LSB-first bit-serial subtractor D = x - y - b0 with start/busy/done
module serial_subtractor_8 #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_subtractor_8_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             x_sign;
  logic             y_sign;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             v_r;

  logic             xi;
  logic             yi;
  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] res_next;

  // Single full-subtractor cell fed by the operand LSBs and the borrow flop
  always_comb begin
    xi          = x_sr[0];
    yi          = y_sr[0];
    diff_bit    = xi ^ yi ^ borrow;
    borrow_next = (~xi & yi) | (~(xi ^ yi) & borrow);
    res_next    = {diff_bit, res_sr[WIDTH-1:1]};
  end

  // Control FSM and datapath; results only update on the last bit so they hold while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x_sr   <= '0;
      y_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      x_sign <= 1'b0;
      y_sign <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      d_r    <= '0;
      bout_r <= 1'b0;
      v_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_sr   <= bus.x;
            y_sr   <= bus.y;
            borrow <= bus.b0;
            res_sr <= '0;
            cnt    <= '0;
            x_sign <= bus.x[WIDTH-1];
            y_sign <= bus.y[WIDTH-1];
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          x_sr   <= x_sr >> 1;
          y_sr   <= y_sr >> 1;
          res_sr <= res_next;
          borrow <= borrow_next;
          if (cnt == LAST) begin
            d_r    <= res_next;
            bout_r <= borrow_next;
            v_r    <= (x_sign != y_sign) & (res_next[WIDTH-1] != x_sign);
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            x_sr   <= bus.x;
            y_sr   <= bus.y;
            borrow <= bus.b0;
            res_sr <= '0;
            cnt    <= '0;
            x_sign <= bus.x[WIDTH-1];
            y_sign <= bus.y[WIDTH-1];
            busy_r <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.D    = d_r;
  assign bus.bOut = bout_r;
  assign bus.V    = v_r;
endmodule

// File: tb/tb_serial_subtractor_8.sv
// tb/tb_serial_subtractor_8.sv - self-checking bench for serial_subtractor_8
module tb_serial_subtractor_8;
  logic clk;
  logic rst;

  serial_subtractor_8_if #(.WIDTH(8)) ifc ();

  serial_subtractor_8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       b0;
    logic [7:0] d;
    logic       bout;
    logic       v;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one operation from a falling edge and returns at the falling edge where done is seen
  task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                        output int lat, output int bcnt, output bit held);
    logic [7:0] prev;
    prev      = ifc.D;
    ifc.start = 1'b1;
    ifc.x     = xv;
    ifc.y     = yv;
    ifc.b0    = bv;
    @(negedge clk);
    ifc.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    held = 1'b1;
    while (ifc.done !== 1'b1 && lat < 30) begin
      if (ifc.busy === 1'b1) bcnt++;
      if (ifc.D !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt;
    bit held;
    logic [8:0] ref9;
    logic [7:0] rx, ry, cap_d;
    logic rb, rv;

    vecs[0] = '{8'd17,  8'd5,   1'b0, 8'd12,  1'b0, 1'b0};
    vecs[1] = '{8'd12,  8'd17,  1'b0, 8'd251, 1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0};
    vecs[3] = '{8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
    vecs[4] = '{8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1};
    vecs[5] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0, 1'b0};
    vecs[6] = '{8'd200, 8'd55,  1'b0, 8'd145, 1'b0, 1'b0};
    vecs[7] = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0};
    vecs[8] = '{8'd5,   8'd5,   1'b1, 8'd255, 1'b1, 1'b0};

    ifc.start = 1'b0;
    ifc.x     = '0;
    ifc.y     = '0;
    ifc.b0    = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_busy", ifc.busy, 0);
    check("reset_done", ifc.done, 0);
    check("reset_d",    ifc.D,    0);
    check("reset_bout", ifc.bOut, 0);
    check("reset_v",    ifc.V,    0);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].b0, lat, bcnt, held);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      check($sformatf("vec%0d_d_held", i), held, 1);
      check($sformatf("vec%0d_d", i), ifc.D, vecs[i].d);
      check($sformatf("vec%0d_bout", i), ifc.bOut, vecs[i].bout);
      check($sformatf("vec%0d_v", i), ifc.V, vecs[i].v);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), ifc.done, 0);
    end

    // Start and operand changes during SHIFT must not disturb the operation in flight
    ifc.start = 1'b1;
    ifc.x     = 8'd200;
    ifc.y     = 8'd55;
    ifc.b0    = 1'b0;
    @(negedge clk);
    dcnt  = 0;
    cap_d = '0;
    for (int i = 1; i <= 25; i++) begin
      if (ifc.done === 1'b1) begin
        dcnt++;
        cap_d = ifc.D;
      end
      if (i <= 8) begin
        ifc.start = i[0];
        ifc.x     = 8'($urandom);
        ifc.y     = 8'($urandom);
        ifc.b0    = 1'($urandom);
      end else begin
        ifc.start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_reject_done_count", dcnt, 1);
    check("busy_reject_d", cap_d, 145);
    check("busy_reject_bout", ifc.bOut, 0);

    // Back-to-back: new start issued in the DONE cycle
    run_op(8'd17, 8'd5, 1'b0, lat, bcnt, held);
    check("b2b_first_d", ifc.D, 12);
    run_op(8'd1, 8'd1, 1'b1, lat, bcnt, held);
    check("b2b_latency", lat, 9);
    check("b2b_busy_cycles", bcnt, 8);
    check("b2b_d", ifc.D, 255);
    check("b2b_bout", ifc.bOut, 1);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation
    ifc.start = 1'b1;
    ifc.x     = 8'd100;
    ifc.y     = 8'd3;
    ifc.b0    = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", ifc.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", ifc.busy, 0);
    check("async_rst_done", ifc.done, 0);
    check("async_rst_d",    ifc.D,    0);
    check("async_rst_bout", ifc.bOut, 0);
    check("async_rst_v",    ifc.V,    0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", ifc.busy, 0);
    run_op(8'd255, 8'd255, 1'b0, lat, bcnt, held);
    check("post_rst_latency", lat, 9);
    check("post_rst_d", ifc.D, 0);
    check("post_rst_bout", ifc.bOut, 0);
    @(negedge clk);

    // Random sweep against a 9-bit reference subtraction
    for (int i = 0; i < 1000; i++) begin
      rx   = 8'($urandom);
      ry   = 8'($urandom);
      rb   = 1'($urandom);
      ref9 = {1'b0, rx} - {1'b0, ry} - {8'd0, rb};
      rv   = (rx[7] != ry[7]) && (ref9[7] != rx[7]);
      run_op(rx, ry, rb, lat, bcnt, held);
      check("rand_latency", lat, 9);
      check("rand_known", 32'($isunknown({ifc.busy, ifc.done, ifc.D, ifc.bOut, ifc.V})), 0);
      check("rand_d", ifc.D, ref9[7:0]);
      check("rand_bout", ifc.bOut, ref9[8]);
      check("rand_v", ifc.V, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
